// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer/status block for an async FIFO: binary/Gray read pointer,
// registered empty, almost-empty, fill level and sticky underflow flags.
module rptr_empty_lvl #(
  parameter int ADDRSIZE  = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                runf_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_LVL = PW'(AE_THRESH);

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] lvl_next;
  logic              rd_en;

  // Next-pointer and level computation; rd_en gates on the registered empty flag.
  always_comb begin
    rd_en      = rinc & ~rempty;
    rbin_next  = rbin + {{ADDRSIZE{1'b0}}, rd_en};
    rgray_next = bin2gray(rbin_next);
    wbin       = gray2bin(rq2_wptr);
    lvl_next   = wbin - rbin_next;
  end

  // Pointer and flag registers all advance on the same edge.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin       <= {PW{1'b0}};
      rptr       <= {PW{1'b0}};
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      rlevel     <= {PW{1'b0}};
      runderflow <= 1'b0;
    end else begin
      rbin    <= rbin_next;
      rptr    <= rgray_next;
      rempty  <= (rgray_next == rq2_wptr);
      raempty <= (lvl_next <= AE_LVL);
      rlevel  <= lvl_next;
      // Set beats clear.
      if (rinc & rempty) begin
        runderflow <= 1'b1;
      end else if (runf_clr) begin
        runderflow <= 1'b0;
      end else begin
        runderflow <= runderflow;
      end
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed self-checking bench for rptr_empty_lvl (ADDRSIZE=3, AE_THRESH=1).
module tb_rptr_empty_lvl;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       rinc;
  logic [3:0] rq2_wptr;
  logic       runf_clr;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [3:0] rlevel;
  logic       runderflow;

  int n_checks = 0;
  int n_errors = 0;

  rptr_empty_lvl #(.ADDRSIZE(3), .AE_THRESH(1)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .runf_clr(runf_clr), .raddr(raddr), .rptr(rptr), .rempty(rempty),
    .raempty(raempty), .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] e_ptr, input logic e_empty,
                             input logic e_ae, input logic [3:0] e_lvl, input logic e_unf);
    check({tag, ".rptr"},  {28'd0, rptr},       {28'd0, e_ptr});
    check({tag, ".empty"}, {31'd0, rempty},     {31'd0, e_empty});
    check({tag, ".ae"},    {31'd0, raempty},    {31'd0, e_ae});
    check({tag, ".lvl"},   {28'd0, rlevel},     {28'd0, e_lvl});
    check({tag, ".unf"},   {31'd0, runderflow}, {31'd0, e_unf});
  endtask

  initial begin
    // 1: reset with rinc held high
    rrst = 1'b1; rinc = 1'b1; rq2_wptr = 4'b0000; runf_clr = 1'b0;
    tick();
    tick();
    check_state("rst", 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
    check("rst.raddr", {29'd0, raddr}, 32'd0);
    rrst = 1'b0;
    tick();
    check_state("post_rst", 4'b0000, 1'b1, 1'b1, 4'd0, 1'b1);

    // 2: five words become visible; clear the sticky flag at the same time
    rinc = 1'b0; rq2_wptr = 4'b0111; runf_clr = 1'b1;
    tick();
    check_state("w5", 4'b0000, 1'b0, 1'b0, 4'd5, 1'b0);
    check("w5.raddr", {29'd0, raddr}, 32'd0);
    runf_clr = 1'b0;
    rinc = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_state($sformatf("rd%0d", i), gray(4'(i)), 1'b0, (i == 4), 4'(5 - i), 1'b0);
      check($sformatf("rd%0d.raddr", i), {29'd0, raddr}, i);
    end

    // 3: drain the last word, then underflow attempts
    tick();
    check_state("drain", 4'b0111, 1'b1, 1'b1, 4'd0, 1'b0);
    tick();
    check_state("unf", 4'b0111, 1'b1, 1'b1, 4'd0, 1'b1);
    runf_clr = 1'b1;
    tick();
    check_state("unf_set_beats_clr", 4'b0111, 1'b1, 1'b1, 4'd0, 1'b1);
    rinc = 1'b0;
    tick();
    check_state("unf_clr", 4'b0111, 1'b1, 1'b1, 4'd0, 1'b0);
    runf_clr = 1'b0;

    // 4: wrap in lock-step, one word kept in flight
    rrst = 1'b1;
    tick();
    rrst = 1'b0; rq2_wptr = gray(4'd1);
    tick();
    check_state("ls_pre", 4'b0000, 1'b0, 1'b1, 4'd1, 1'b0);
    rinc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rq2_wptr = gray(4'(k + 2));
      tick();
      check_state($sformatf("ls%0d", k), gray(4'(k + 1)), 1'b0, 1'b1, 4'd1, 1'b0);
      check($sformatf("ls%0d.raddr", k), {29'd0, raddr}, (k + 1) % 8);
    end
    tick();
    check_state("ls_drain", gray(4'd5), 1'b1, 1'b1, 4'd0, 1'b0);
    check("ls_drain.raddr", {29'd0, raddr}, 32'd5);
    rinc = 1'b0;

    // 5: full FIFO
    rrst = 1'b1; rq2_wptr = 4'b0000;
    tick();
    rrst = 1'b0; rq2_wptr = 4'b1100;
    tick();
    check_state("full", 4'b0000, 1'b0, 1'b0, 4'd8, 1'b0);

    // 6: reset mid-stream
    rrst = 1'b1;
    tick();
    rrst = 1'b0; rq2_wptr = 4'b0111;
    tick();
    rinc = 1'b1;
    tick();
    tick();
    check_state("mid", gray(4'd2), 1'b0, 1'b0, 4'd3, 1'b0);
    check("mid.raddr", {29'd0, raddr}, 32'd2);
    rrst = 1'b1;
    tick();
    check_state("mid_rst", 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
    check("mid_rst.raddr", {29'd0, raddr}, 32'd0);
    rrst = 1'b0; rq2_wptr = 4'b0000;
    tick();
    check_state("mid_unf", 4'b0000, 1'b1, 1'b1, 4'd0, 1'b1);
    rinc = 1'b0; runf_clr = 1'b1;
    tick();
    check_state("mid_clr", 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
    runf_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
